// File: rtl/divmmc_spi.sv
// rtl/divmmc_spi.sv - DivMMC CPU-side SPI master (mode 0, byte transfers, MSB first)
module divmmc_spi #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] cpu_din,
    input  logic       data_wr,
    input  logic       data_rd,
    input  logic       ctrl_wr,
    output logic [7:0] cpu_dout,
    output logic       busy,
    output logic       sd_cs,
    output logic       sd_sck,
    output logic       sd_sdi,
    input  logic       sd_sdo
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] rx_data;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;

    logic phase_end;
    logic sck_rise;
    logic sck_fall;
    logic last_fall;
    logic start;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The completion edge doubles as an accept slot so bytes can run back to back.
    always_comb begin
        state_next = state;
        phase_end  = (div_cnt == DIV_LAST);
        sck_rise   = 1'b0;
        sck_fall   = 1'b0;
        last_fall  = 1'b0;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                start = data_wr | data_rd;
            end
            ST_XFER: begin
                if (phase_end) begin
                    sck_rise  = ~sd_sck;
                    sck_fall  = sd_sck;
                    last_fall = sd_sck & (bit_cnt == 3'd7);
                end
                start = last_fall & (data_wr | data_rd);
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (start) begin
            state_next = ST_XFER;
        end else if (last_fall) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sd_cs    <= 1'b1;
            sd_sck   <= 1'b0;
            tx_shift <= 8'hFF;
            rx_shift <= 8'hFF;
            rx_data  <= 8'hFF;
            div_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
        end else begin
            if (ctrl_wr) begin
                sd_cs <= cpu_din[0];
            end
            if (last_fall) begin
                rx_data <= rx_shift;
            end
            if (start) begin
                tx_shift <= data_wr ? cpu_din : 8'hFF;
                sd_sck   <= 1'b0;
                div_cnt  <= 8'd0;
                bit_cnt  <= 3'd0;
            end else if (state == ST_XFER) begin
                div_cnt <= phase_end ? 8'd0 : div_cnt + 8'd1;
                if (sck_rise) begin
                    sd_sck   <= 1'b1;
                    rx_shift <= {rx_shift[6:0], sd_sdo};
                end
                if (sck_fall) begin
                    sd_sck   <= 1'b0;
                    tx_shift <= {tx_shift[6:0], 1'b1};
                    bit_cnt  <= bit_cnt + 3'd1;
                end
            end
        end
    end

    // tx_shift fills with ones, so it reads 0xFF whenever idle and MOSI idles high.
    assign sd_sdi   = tx_shift[7];
    assign busy     = (state == ST_XFER);
    assign cpu_dout = rx_data;

endmodule
